// File: rtl/inst_sequencer.sv
// Instruction sequencer for a systolic core: kernel load/push, activation
// load/execute, and output FIFO drain into psum memory, repeated per kernel position.
module inst_sequencer #(
    parameter int unsigned row     = 8,
    parameter int unsigned col     = 8,
    parameter int unsigned len_kij = 9,
    parameter int unsigned len_nij = 36,
    parameter logic [10:0] w_base  = 11'd64,
    parameter logic [10:0] a_base  = 11'd0,
    parameter logic [10:0] p_base  = 11'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        ofifo_valid,
    output logic [33:0] inst,
    output logic        busy,
    output logic        done
);

    localparam int unsigned IW      = 34;
    localparam int unsigned AW      = 11;
    localparam int unsigned M1      = (row + 1 > col) ? row + 1 : col;
    localparam int unsigned CNT_MAX = (M1 > len_nij + 1) ? M1 : len_nij + 1;
    localparam int unsigned CW      = $clog2(CNT_MAX);
    localparam int unsigned KW      = (len_kij > 1) ? $clog2(len_kij) : 1;
    localparam int unsigned RW      = $clog2(len_nij + 1);

    localparam logic [IW-1:0] IDLE_WORD = 34'h1_800C_0000;

    typedef enum logic [2:0] {
        IDLE,
        KLOAD,
        KPUSH,
        ALOAD,
        AEXEC,
        DRAIN,
        DONE
    } state_t;

    state_t          state;
    logic [KW-1:0]   k;
    logic [CW-1:0]   cnt;
    logic [RW-1:0]   rd_cnt;
    logic            rd_flag;
    logic            wr_flag;
    logic [RW-1:0]   wr_idx;

    logic            drain_rd_c;
    logic [RW-1:0]   rd_idx_c;
    logic            last_wr_c;

    // xmem read with optional L0 write; the write lags the read by one cycle
    function automatic logic [IW-1:0] xrd_word(input logic [AW-1:0] addr,
                                               input logic rd_en,
                                               input logic wr_en);
        logic [IW-1:0] w;
        w = IDLE_WORD;
        if (rd_en) begin
            w[19]   = 1'b0;
            w[17:7] = addr;
        end
        w[2] = wr_en;
        return w;
    endfunction

    function automatic logic [IW-1:0] kload_word(input logic [KW-1:0] kk,
                                                 input logic [CW-1:0] c);
        logic [AW-1:0] addr;
        addr = w_base + AW'(32'(kk) * row + 32'(c));
        return xrd_word(addr, c < CW'(row), c != '0);
    endfunction

    function automatic logic [IW-1:0] aload_word(input logic [CW-1:0] c);
        logic [AW-1:0] addr;
        addr = a_base + AW'(c);
        return xrd_word(addr, c < CW'(len_nij), c != '0);
    endfunction

    function automatic logic [IW-1:0] kpush_word();
        logic [IW-1:0] w;
        w    = IDLE_WORD;
        w[3] = 1'b1;
        w[0] = 1'b1;
        return w;
    endfunction

    function automatic logic [IW-1:0] aexec_word();
        logic [IW-1:0] w;
        w    = IDLE_WORD;
        w[3] = 1'b1;
        w[1] = 1'b1;
        return w;
    endfunction

    // FIFO read plus the pmem write of the previous cycle's read
    function automatic logic [IW-1:0] drain_word(input logic rd,
                                                 input logic wr,
                                                 input logic [RW-1:0] d,
                                                 input logic [KW-1:0] kk);
        logic [IW-1:0] w;
        w    = IDLE_WORD;
        w[6] = rd;
        if (wr) begin
            w[33]    = (kk != '0);
            w[32]    = 1'b0;
            w[31]    = 1'b0;
            w[30:20] = p_base + AW'(d);
        end
        return w;
    endfunction

    // Read decision for the next cycle; rd_cnt is zero on DRAIN entry
    always_comb begin
        drain_rd_c = ofifo_valid && (rd_cnt < RW'(len_nij));
        rd_idx_c   = rd_cnt - RW'(1);
        last_wr_c  = wr_flag && (wr_idx == RW'(len_nij - 1));
    end

    // Outputs are computed for the state being entered so inst lines up with state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            k       <= '0;
            cnt     <= '0;
            rd_cnt  <= '0;
            rd_flag <= 1'b0;
            wr_flag <= 1'b0;
            wr_idx  <= '0;
            inst    <= IDLE_WORD;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            inst <= IDLE_WORD;
            busy <= 1'b1;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        state <= KLOAD;
                        k     <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        inst  <= kload_word('0, '0);
                    end
                end
                KLOAD: begin
                    if (cnt == CW'(row)) begin
                        state <= KPUSH;
                        cnt   <= '0;
                        inst  <= kpush_word();
                    end else begin
                        cnt  <= cnt + CW'(1);
                        inst <= kload_word(k, cnt + CW'(1));
                    end
                end
                KPUSH: begin
                    if (cnt == CW'(col - 1)) begin
                        state <= ALOAD;
                        cnt   <= '0;
                        inst  <= aload_word('0);
                    end else begin
                        cnt  <= cnt + CW'(1);
                        inst <= kpush_word();
                    end
                end
                ALOAD: begin
                    if (cnt == CW'(len_nij)) begin
                        state <= AEXEC;
                        cnt   <= '0;
                        inst  <= aexec_word();
                    end else begin
                        cnt  <= cnt + CW'(1);
                        inst <= aload_word(cnt + CW'(1));
                    end
                end
                AEXEC: begin
                    if (cnt == CW'(len_nij - 1)) begin
                        state   <= DRAIN;
                        cnt     <= '0;
                        rd_cnt  <= RW'(drain_rd_c);
                        rd_flag <= drain_rd_c;
                        wr_flag <= 1'b0;
                        wr_idx  <= '0;
                        inst    <= drain_word(drain_rd_c, 1'b0, '0, k);
                    end else begin
                        cnt  <= cnt + CW'(1);
                        inst <= aexec_word();
                    end
                end
                DRAIN: begin
                    if (last_wr_c) begin
                        rd_cnt  <= '0;
                        rd_flag <= 1'b0;
                        wr_flag <= 1'b0;
                        wr_idx  <= '0;
                        cnt     <= '0;
                        if (k == KW'(len_kij - 1)) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= KLOAD;
                            k     <= k + KW'(1);
                            inst  <= kload_word(k + KW'(1), '0);
                        end
                    end else begin
                        rd_cnt  <= rd_cnt + RW'(drain_rd_c);
                        rd_flag <= drain_rd_c;
                        wr_flag <= rd_flag;
                        wr_idx  <= rd_idx_c;
                        inst    <= drain_word(drain_rd_c, rd_flag, rd_idx_c, k);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/inst_sequencer.md
INST_SEQUENCER -- requirements
Module: inst_sequencer

Interface
REQ-001 SHALL have parameter row, default 8, meaning PE rows (L0 word count per kernel load).
REQ-002 SHALL have parameter col, default 8, meaning PE columns (kernel push cycles).
REQ-003 SHALL have parameter len_kij, default 9, meaning kernel positions per run.
REQ-004 SHALL have parameter len_nij, default 36, meaning output pixels per kernel position.
REQ-005 SHALL have parameters w_base (default 11'd64), a_base (default 11'd0) and p_base (default 11'd0), meaning the kernel xmem, activation xmem and psum pmem base addresses.
REQ-006 SHALL have port clk, input, 1, meaning the single clock.
REQ-007 SHALL have port reset, input, 1, meaning the asynchronous active-high reset.
REQ-008 SHALL have port start, input, 1, meaning a one-cycle request to begin a run.
REQ-009 SHALL have port ofifo_valid, input, 1, meaning output FIFO holds a full row.
REQ-010 SHALL have port inst, output, 34, meaning the registered instruction word to the core.
REQ-011 SHALL have port busy, output, 1, meaning high in every state other than IDLE.
REQ-012 SHALL have port done, output, 1, meaning a one-cycle pulse at the end of a run.

Function
REQ-013 SHALL use inst field map acc[33], CEN_pmem[32], WEN_pmem[31], A_pmem[30:20], CEN_xmem[19], WEN_xmem[18], A_xmem[17:7], ofifo_rd[6], reserved[5:4]=0, l0_rd[3], l0_wr[2], execute[1], load[0].
REQ-014 SHALL drive the idle word in IDLE: CEN_pmem=1, WEN_pmem=1, CEN_xmem=1, WEN_xmem=1, all other bits 0.
REQ-015 SHALL drive all outputs from flops, with no combinational path from any input to any output.
REQ-016 SHALL implement FSM states IDLE, KLOAD, KPUSH, ALOAD, AEXEC, DRAIN and DONE, with the kernel index k running from 0 to len_kij-1.
REQ-017 SHALL leave IDLE for KLOAD with k=0 when start=1; start SHALL be ignored in every other state.
REQ-018 SHALL hold KLOAD for row+1 cycles.
- Cycles 0..row-1: xmem read (CEN_xmem=0, WEN_xmem=1), A_xmem=w_base+k*row+i.
- Cycles 1..row: l0_wr=1, covering the 1-cycle SRAM read latency.
REQ-019 SHALL hold KPUSH for col cycles with l0_rd=1 and load=1.
REQ-020 SHALL hold ALOAD for len_nij+1 cycles.
- Cycles 0..len_nij-1: xmem read, A_xmem=a_base+j.
- Cycles 1..len_nij: l0_wr=1.
REQ-021 SHALL hold AEXEC for len_nij cycles with l0_rd=1 and execute=1.
REQ-022 SHALL, in DRAIN, assert ofifo_rd=1 in each cycle ofifo_valid=1 and hold ofifo_rd=0 otherwise (stall).
REQ-023 SHALL, one cycle after each ofifo_rd, write pmem with CEN_pmem=0, WEN_pmem=0, A_pmem=p_base+d and acc=(k!=0), where d is the index of that read.
REQ-024 SHALL leave DRAIN after len_nij reads plus the final pmem write cycle.
- To KLOAD with k+1 if k<len_kij-1.
- Otherwise to DONE.
REQ-025 SHALL, in DONE, drive the idle word with done=1 for exactly one cycle, then return to IDLE.
REQ-026 SHALL size all counters to clog2 of the largest count, and SHALL wrap address sums modulo 2^11.
REQ-027 SHALL ignore ofifo_valid outside DRAIN.

Reset
REQ-028 SHALL, while reset=1, asynchronously force state IDLE, k=0, all counters 0, inst=idle word, busy=0 and done=0, including when reset hits mid-run.
REQ-029 SHALL start a new run only from a start pulse seen after reset deasserts.

Verification
REQ-030 SHALL cover reset mid-AEXEC -> next cycle inst=34'h1_800C_0000, busy=0, no write follows.
REQ-031 SHALL cover start with len_kij=1, len_nij=4 and ofifo_valid tied 1.
- 9 KLOAD, 8 KPUSH, 5 ALOAD, 4 AEXEC and 5 DRAIN cycles, then a done pulse.
- Total busy cycles: 32.
REQ-032 SHALL cover kernel addressing with len_kij=2 -> second KLOAD reads A_xmem 72..79, and all k=1 pmem writes have acc=1 while k=0 writes have acc=0.
REQ-033 SHALL cover ofifo_valid low for 3 cycles mid-DRAIN -> ofifo_rd=0 during the stall, no extra writes, and pmem A_pmem sequence 0,1,2,3 unbroken.
REQ-034 SHALL cover start pulsed during KPUSH -> no effect, and a single done pulse at run end.
